// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : CPU / VGA / memory bus bundle for mem_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          vga_req;
  logic [AW-1:0] vga_adr;
  logic [DW-1:0] vga_rdata;
  logic          vga_valid;
  logic          vga_ovf;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata, vga_req, vga_adr, mem_rdata,
    output cpu_rdata, cpu_ready, vga_rdata, vga_valid, vga_ovf,
           mem_we, mem_adr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata, vga_req, vga_adr, mem_rdata,
    input  cpu_rdata, cpu_ready, vga_rdata, vga_valid, vga_ovf,
           mem_we, mem_adr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : single-port memory sequencer, VGA priority with CPU streak cap
// Optional macro MEMARB_STATS_EN adds stat_cpu_wait / stat_vga_grants.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_VGA_STREAK = 4
) (
  input  wire logic   clk,
  input  wire logic   clr,
  mem_arbiter_if.slave bus
`ifdef MEMARB_STATS_EN
  ,
  output logic [15:0] stat_cpu_wait,
  output logic [15:0] stat_vga_grants
`endif
);

  localparam int SW = $clog2(MAX_VGA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VGA_STREAK);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VGA_ADDR = 3'd1,
    VGA_DATA = 3'd2,
    CPU_ADDR = 3'd3,
    CPU_DATA = 3'd4
  } state_t;

  state_t        state;
  logic          pend;
  logic [AW-1:0] pend_adr;
  logic [SW-1:0] streak;
  logic          lat_we;
  logic [AW-1:0] lat_adr;
  logic [DW-1:0] lat_wdata;
  logic          cpu_eff;
  logic          vga_grant;
  logic          cpu_grant;

  // The request still visible during the ready pulse belongs to the finished access.
  assign cpu_eff   = bus.cpu_req && !bus.cpu_ready;
  assign vga_grant = (state == IDLE) && pend && (!cpu_eff || (streak < STREAK_MAX));
  assign cpu_grant = (state == IDLE) && !vga_grant && cpu_eff;

  assign bus.mem_we    = (state == CPU_ADDR) && lat_we;
  assign bus.mem_adr   = (state == VGA_ADDR) ? pend_adr :
                         (state == CPU_ADDR) ? lat_adr  : '0;
  assign bus.mem_wdata = ((state == CPU_ADDR) && lat_we) ? lat_wdata : '0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      pend          <= 1'b0;
      pend_adr      <= '0;
      streak        <= '0;
      lat_we        <= 1'b0;
      lat_adr       <= '0;
      lat_wdata     <= '0;
      bus.cpu_rdata <= '0;
      bus.cpu_ready <= 1'b0;
      bus.vga_rdata <= '0;
      bus.vga_valid <= 1'b0;
      bus.vga_ovf   <= 1'b0;
    end else begin
      bus.cpu_ready <= 1'b0;
      bus.vga_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (vga_grant) begin
            state <= VGA_ADDR;
          end else if (cpu_grant) begin
            state     <= CPU_ADDR;
            lat_we    <= bus.cpu_we;
            lat_adr   <= bus.cpu_adr;
            lat_wdata <= bus.cpu_wdata;
          end
        end
        VGA_ADDR: state <= VGA_DATA;
        VGA_DATA: begin
          bus.vga_rdata <= bus.mem_rdata;
          bus.vga_valid <= 1'b1;
          state         <= IDLE;
        end
        CPU_ADDR: state <= CPU_DATA;
        CPU_DATA: begin
          bus.cpu_rdata <= bus.mem_rdata;
          bus.cpu_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A request landing in VGA_DATA replaces the slot being freed.
      if (bus.vga_req) begin
        if (!pend || (state == VGA_DATA)) begin
          pend     <= 1'b1;
          pend_adr <= bus.vga_adr;
        end else begin
          bus.vga_ovf <= 1'b1;
        end
      end else if (state == VGA_DATA) begin
        pend <= 1'b0;
      end

      if (cpu_grant || ((state == IDLE) && !bus.cpu_req)) begin
        streak <= '0;
      end else if (vga_grant && bus.cpu_req && (streak != STREAK_MAX)) begin
        streak <= streak + SW'(1);
      end
    end
  end

`ifdef MEMARB_STATS_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stat_cpu_wait   <= 16'h0000;
      stat_vga_grants <= 16'h0000;
    end else begin
      if (cpu_eff && !cpu_grant && (state != CPU_ADDR) && (state != CPU_DATA)
          && (stat_cpu_wait != 16'hFFFF)) begin
        stat_cpu_wait <= stat_cpu_wait + 16'h0001;
      end
      if (vga_grant && (stat_vga_grants != 16'hFFFF)) begin
        stat_vga_grants <= stat_vga_grants + 16'h0001;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a synchronous memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] CPU_A = 32'h0000_0100;
  localparam logic [31:0] VGA_A = 32'h0000_2000;
  localparam logic [31:0] VGA_B = 32'h0000_2040;

  typedef struct {
    logic        dc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cpu_acks = 0;
  int   vga_acks = 0;
  bit   rec_grants = 1'b0;
  bit   grant_seq[$];
  exp_t cpu_q[$];
  logic [31:0] vga_q[$];
  exp_t e_cpu;
  logic [31:0] e_vga;
  logic [31:0] wmem [logic [31:0]];

`ifdef MEMARB_STATS_EN
  logic [15:0] stat_cpu_wait;
  logic [15:0] stat_vga_grants;
  int  m_wait = 0;
  int  m_vga = 0;
  bit  prev_cpu_addr = 1'b0;
`endif

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_VGA_STREAK(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef MEMARB_STATS_EN
    ,
    .stat_cpu_wait   (stat_cpu_wait),
    .stat_vga_grants (stat_vga_grants)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return 32'hC0DE_0000 | (a >> 2);
  endfunction

  function automatic bit is_cpu_adr(logic [31:0] a);
    return (a != 32'h0) && (a < 32'h1000);
  endfunction

  // Synchronous memory, read-before-write, one-cycle latency.
  always @(posedge clk) begin
    bus.mem_rdata <= wmem.exists(bus.mem_adr) ? wmem[bus.mem_adr] : init_word(bus.mem_adr);
    if (bus.mem_we) wmem[bus.mem_adr] = bus.mem_wdata;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!clr) begin
`ifdef MEMARB_STATS_EN
      m_wait = 0;
      m_vga = 0;
      prev_cpu_addr = 1'b0;
`endif
    end else begin
      if (bus.cpu_ready) begin
        cpu_acks++;
        if (cpu_q.size() == 0) check("cpu_ready_unexpected", 32'(cpu_q.size()), 32'd1);
        else begin
          e_cpu = cpu_q.pop_front();
          if (!e_cpu.dc) check("cpu_rdata", bus.cpu_rdata, e_cpu.data);
        end
      end
      if (bus.vga_valid) begin
        vga_acks++;
        if (vga_q.size() == 0) check("vga_valid_unexpected", 32'(vga_q.size()), 32'd1);
        else begin
          e_vga = vga_q.pop_front();
          check("vga_rdata", bus.vga_rdata, e_vga);
        end
      end
      if (rec_grants && (bus.mem_adr != 32'h0)) grant_seq.push_back(is_cpu_adr(bus.mem_adr));
`ifdef MEMARB_STATS_EN
      // The cycle before an observed CPU address phase was the grant, not a wait.
      if (is_cpu_adr(bus.mem_adr)) m_wait--;
      if (bus.cpu_req && !bus.cpu_ready && !is_cpu_adr(bus.mem_adr) && !prev_cpu_addr) m_wait++;
      if (bus.mem_adr >= 32'h2000) m_vga++;
      prev_cpu_addr = is_cpu_adr(bus.mem_adr);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_issue(logic we, logic [31:0] a, logic [31:0] d);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_adr   = a;
    bus.cpu_wdata = d;
  endtask

  task automatic wait_for(input bit is_vga, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
      bus.vga_req = 1'b0;
    end while (!(is_vga ? bus.vga_valid : bus.cpu_ready) && (lat < 20));
  endtask

  task automatic check_zero(string p);
    check({p, "_mem_we"},    {31'b0, bus.mem_we},    32'h0);
    check({p, "_mem_adr"},   bus.mem_adr,            32'h0);
    check({p, "_mem_wdata"}, bus.mem_wdata,          32'h0);
    check({p, "_cpu_ready"}, {31'b0, bus.cpu_ready}, 32'h0);
    check({p, "_vga_valid"}, {31'b0, bus.vga_valid}, 32'h0);
    check({p, "_vga_ovf"},   {31'b0, bus.vga_ovf},   32'h0);
    check({p, "_cpu_rdata"}, bus.cpu_rdata,          32'h0);
    check({p, "_vga_rdata"}, bus.vga_rdata,          32'h0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #3 clr = 1'b0;
    @(posedge clk);
    #3 clr = 1'b1;
    tick();
  endtask

  initial begin
    int lat;
    int acks0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_adr = '0; bus.cpu_wdata = '0;
    bus.vga_req = 1'b0; bus.vga_adr = '0;

    @(posedge clk); #1;
    check_zero("por");
    #2 clr = 1'b1;
    #1 check_zero("por_released");
    tick();

    // Idle-bus CPU write.
    cpu_issue(1'b1, 32'h40, 32'hDEAD_BEEF);
    cpu_q.push_back('{dc: 1'b1, data: 32'h0});
    tick();
    check("wr_mem_we",    {31'b0, bus.mem_we}, 32'h1);
    check("wr_mem_adr",   bus.mem_adr,         32'h40);
    check("wr_mem_wdata", bus.mem_wdata,       32'hDEAD_BEEF);
    tick();
    check("wr_we_one_cycle", {31'b0, bus.mem_we}, 32'h0);
    tick();
    check("wr_ready_at_3", {31'b0, bus.cpu_ready}, 32'h1);
    bus.cpu_req = 1'b0;
    tick();

    // Read back.
    cpu_issue(1'b0, 32'h40, 32'h0);
    cpu_q.push_back('{dc: 1'b0, data: 32'hDEAD_BEEF});
    wait_for(1'b0, lat);
    check("rd_latency", 32'(lat), 32'd3);
    bus.cpu_req = 1'b0;
    tick();

    // Lone VGA fetch.
    acks0 = cpu_acks;
    bus.vga_req = 1'b1; bus.vga_adr = VGA_A;
    vga_q.push_back(init_word(VGA_A));
    wait_for(1'b1, lat);
    check("vga_latency", 32'(lat), 32'd4);
    tick();
    check("vga_no_cpu_ready", 32'(cpu_acks - acks0), 32'd0);

    // Reset asserted during CPU_ADDR of a write; the write is lost.
    cpu_issue(1'b1, 32'h80, 32'h1234_5678);
    tick();
    check("rst_pre_we", {31'b0, bus.mem_we}, 32'h1);
    #2 clr = 1'b0;
    #1 check_zero("rst_mid");
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #3 clr = 1'b1;
    #1 check_zero("rst_released");
    tick();
    cpu_issue(1'b0, 32'h80, 32'h0);
    cpu_q.push_back('{dc: 1'b0, data: init_word(32'h80)});
    wait_for(1'b0, lat);
    check("rst_lost_write_lat", 32'(lat), 32'd3);
    bus.cpu_req = 1'b0;
    tick();

    // Overflow: second request while the first is still pending.
    acks0 = vga_acks;
    bus.vga_req = 1'b1; bus.vga_adr = VGA_A;
    vga_q.push_back(init_word(VGA_A));
    tick();
    bus.vga_req = 1'b0;
    tick();
    bus.vga_req = 1'b1; bus.vga_adr = VGA_B;
    wait_for(1'b1, lat);
    check("ovf_first_lat", 32'(lat), 32'd2);
    check("ovf_set", {31'b0, bus.vga_ovf}, 32'h1);
    repeat (6) tick();
    check("ovf_sticky", {31'b0, bus.vga_ovf}, 32'h1);
    check("ovf_one_valid", 32'(vga_acks - acks0), 32'd1);
    pulse_clr();
    check("ovf_cleared", {31'b0, bus.vga_ovf}, 32'h0);

    // Request coinciding with VGA_DATA is accepted.
    bus.vga_req = 1'b1; bus.vga_adr = VGA_A;
    vga_q.push_back(init_word(VGA_A));
    tick();
    bus.vga_req = 1'b0;
    tick();
    tick();
    bus.vga_req = 1'b1; bus.vga_adr = VGA_B;
    vga_q.push_back(init_word(VGA_B));
    wait_for(1'b1, lat);
    check("coin_first_lat", 32'(lat), 32'd1);
    wait_for(1'b1, lat);
    check("coin_second_lat", 32'(lat), 32'd3);
    check("coin_no_ovf", {31'b0, bus.vga_ovf}, 32'h0);
    tick();

    // Contention: CPU held, VGA every 3 cycles.
    pulse_clr();
    acks0 = cpu_acks;
    grant_seq.delete();
    rec_grants = 1'b1;
    for (int c = 0; c <= 30; c++) begin
      if (c % 3 == 0) begin
        bus.vga_req = 1'b1; bus.vga_adr = VGA_B;
        vga_q.push_back(init_word(VGA_B));
      end else begin
        bus.vga_req = 1'b0;
      end
      if (c == 1) begin
        cpu_issue(1'b0, CPU_A, 32'h0);
        cpu_q.push_back('{dc: 1'b0, data: init_word(CPU_A)});
      end else if ((c > 1) && bus.cpu_ready) begin
        cpu_q.push_back('{dc: 1'b0, data: init_word(CPU_A)});
      end
      tick();
    end
    bus.vga_req = 1'b0;
    check("cont_ready_31", {31'b0, bus.cpu_ready}, 32'h1);
    bus.cpu_req = 1'b0;
    repeat (12) tick();
    rec_grants = 1'b0;
    check("cont_grant_count", 32'(grant_seq.size()), 32'd11);
    foreach (grant_seq[i]) begin
      check($sformatf("cont_grant_%0d", i), {31'b0, grant_seq[i]}, {31'b0, (i % 5) == 4});
    end
    check("cont_cpu_acks", 32'(cpu_acks - acks0), 32'd2);
    check("cont_vga_dropped", 32'(vga_q.size()), 32'd2);
    check("cont_ovf", {31'b0, bus.vga_ovf}, 32'h1);
    vga_q.delete();
`ifdef MEMARB_STATS_EN
    check("stat_vga_grants", {16'h0, stat_vga_grants}, 32'(m_vga));
    check("stat_cpu_wait",   {16'h0, stat_cpu_wait},   32'(m_wait));
`endif

    check("end_cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    check("end_vga_q_empty", 32'(vga_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single port of the unified instruction/data/framebuffer memory between the multicycle MIPS core and the VGA scanout fetch. It sits between `mips`, `vga640x480` and `mem` in the top level, all on the 25 MHz pixel clock.
- VGA fetches have priority so the display never tears.
- A streak limiter guarantees the CPU forward progress.
- Stalled CPU accesses are held off with a ready handshake.

## Interface
- `AW`, 32, address width (byte address, word-aligned).
- `DW`, 32, data width.
- `MAX_VGA_STREAK`, 4, maximum consecutive VGA grants while a CPU request is waiting.
- `clk`  in  1  system clock (25 MHz pixel clock).
- `clr`  in  1  reset; one clock, reset is asynchronous and active-low.
- `cpu_req`  in  1  CPU access request, held until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_adr`  in  AW  CPU address.
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  CPU read data, valid while `cpu_ready`.
- `cpu_ready`  out  1  one-cycle completion pulse, for reads and writes.
- `vga_req`  in  1  one-cycle pulse requesting one word.
- `vga_adr`  in  AW  fetch address, sampled with `vga_req`.
- `vga_rdata`  out  DW  fetched word, valid while `vga_valid`.
- `vga_valid`  out  1  one-cycle pulse.
- `vga_ovf`  out  1  sticky: a VGA request was dropped.
- `mem_we`  out  1  memory write enable.
- `mem_adr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, synchronous, one-cycle latency.

## Operation
- Pending VGA register (`pend`, `pend_adr`): set on `vga_req`, cleared at the end of `VGA_DATA`.
  - A `vga_req` arriving while `pend` is set and not clearing that cycle is dropped and sets `vga_ovf`.
  - A `vga_req` arriving in the cycle `pend` clears is accepted.
- FSM states: `IDLE`, `VGA_ADDR`, `VGA_DATA`, `CPU_ADDR`, `CPU_DATA`.
- `IDLE` transitions:
  - If `pend` and (`!cpu_req` or `streak < MAX_VGA_STREAK`), go to `VGA_ADDR`.
  - Otherwise, if `cpu_req` is effective, go to `CPU_ADDR`.
  - Otherwise, stay in `IDLE`.
  - CPU request fields are latched on entry to `CPU_ADDR`.
- `*_ADDR` states:
  - `mem_adr` = granted address.
  - In `CPU_ADDR` with a write, `mem_we` = 1 and `mem_wdata` = latched data.
  - Next state is `*_DATA`.
- `*_DATA` states:
  - `mem_rdata` is registered into `vga_rdata`/`cpu_rdata`; the corresponding valid/ready is asserted in the following cycle for exactly one cycle.
  - Next state is `IDLE`.
- `cpu_req` is ignored in the cycle `cpu_ready` is high. The CPU may drop it or present a new request afterwards.
- Streak counter, width clog2(MAX_VGA_STREAK+1):
  - Increments on each VGA grant made while `cpu_req` is high; saturates.
  - Clears on a CPU grant, and whenever `cpu_req` is low in `IDLE`.
- `mem_we` and `mem_adr` are combinational from state and latched fields. Outside `*_ADDR`: `mem_we` = 0 and `mem_adr` = 0.
- CPU write data returned on `cpu_rdata` is don't-care.

## Timing
- Access occupancy: 3 cycles (`ADDR`, `DATA`, `IDLE`).
- Idle-bus latency:
  - `vga_req` at cycle 0 gives `vga_valid` at cycle 4.
  - `cpu_req` first seen in `IDLE` at cycle 0 gives `cpu_ready` at cycle 3.
- Worst-case CPU wait: `MAX_VGA_STREAK`×3 cycles plus its own access.
- Reset (`clr` low, asynchronous, at any point including mid-write):
  - state = `IDLE`; `pend`, `streak`, `vga_ovf` = 0.
  - All outputs 0, so `mem_we` falls immediately.
  - Outputs stay 0 until the first rising edge after `clr` is released.
- An interrupted CPU access is lost. The CPU is reset by the same `clr`.

## Configuration
- `MEMARB_STATS_EN`: when defined, adds two outputs:
  - `stat_cpu_wait` [15:0]: counts cycles with `cpu_req` high and no grant.
  - `stat_vga_grants` [15:0]: counts VGA grants.
  - Both counters saturate at 16'hFFFF and reset to 0 on `clr`.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

## Test plan
- Reset: hold `clr` low during a CPU write in `CPU_ADDR` -> `mem_we` drops in the same cycle; all outputs 0; `vga_ovf` = 0.
- Idle CPU access:
  - `cpu_we`=1, `cpu_adr`=0x40, `cpu_wdata`=0xDEADBEEF -> `mem_we` high one cycle with those values, `cpu_ready` at +3.
  - A subsequent read of 0x40 returns 0xDEADBEEF.
- Lone VGA fetch: `vga_req` with `vga_adr`=0x2000 on an idle bus -> `vga_valid` at +4 with the memory word at 0x2000; no `cpu_ready`.
- Contention: `cpu_req` held while a `vga_req` is issued every 3 cycles -> exactly 4 VGA grants, then one CPU grant; streak reset; pattern repeats.
- Overflow: two `vga_req` pulses 1 cycle apart -> second dropped, `vga_ovf`=1 until `clr`; a `vga_req` coinciding with `VGA_DATA` is accepted, `vga_ovf` stays 0.
- Stats (`MEMARB_STATS_EN`): contention scenario run for 30 cycles -> `stat_vga_grants` and `stat_cpu_wait` match the scoreboard count.
